// File: rtl/hazard_pkg.sv
// Shared opcode/funct constants and FSM state type for the IF/ID hazard controller.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic {
    RUN   = 1'b0,
    HOLD2 = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard classification of the ID instruction against the EX and MEM destinations.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [31:0] id_inst,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_write_reg,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_write_reg,
  output logic        single_haz,
  output logic        double_haz
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       is_rtype;
  logic       is_beq;
  logic       is_bne;
  logic       is_sw;
  logic       use_rt;
  logic       is_br;
  logic       match_ex;
  logic       match_mem;
  logic       h1;
  logic       h2;
  logic       h3;
  logic       h4;
  logic       unused_inst_bits;

  assign op    = id_inst[31:26];
  assign rs    = id_inst[25:21];
  assign rt    = id_inst[20:16];
  assign funct = id_inst[5:0];
  assign unused_inst_bits = ^id_inst[15:6];

  assign is_rtype = (op == OP_RTYPE);
  assign is_beq   = (op == OP_BEQ);
  assign is_bne   = (op == OP_BNE);
  assign is_sw    = (op == OP_SW);

  assign use_rt = is_rtype | is_beq | is_bne | is_sw;
  assign is_br  = is_beq | is_bne | (is_rtype & (funct == FUNCT_JR));

  // $0 is hardwired to zero, so it never creates a dependency.
  assign match_ex  = ((rs == ex_write_reg) & (rs != 5'd0)) |
                     (use_rt & (rt == ex_write_reg) & (rt != 5'd0));
  assign match_mem = ((rs == mem_write_reg) & (rs != 5'd0)) |
                     (use_rt & (rt == mem_write_reg) & (rt != 5'd0));

  assign h1 = ~is_br & ex_mem_read & match_ex;
  assign h2 = is_br & ex_reg_write & ~ex_mem_read & match_ex;
  assign h3 = is_br & ex_mem_read & match_ex;
  assign h4 = is_br & mem_mem_read & match_mem;

  assign double_haz = h3;
  assign single_haz = (h1 | h2 | h4) & ~h3;

endmodule

// File: rtl/hazard_ctrl.sv
// IF/ID and PC hold controller: single/double stall sequencing plus a stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] ID_Inst,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_WriteReg,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_WriteReg,
  output logic        stall,
  output logic        stallstall,
  output logic        PC_En,
  output logic        ID_EX_Flush,
  output logic [31:0] stall_cycles
);

  state_e      state_q;
  state_e      state_d;
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;
  logic        single_haz;
  logic        double_haz;
  logic        flush;

  hazard_detect u_detect (
    .id_inst       (ID_Inst),
    .ex_reg_write  (EX_RegWrite),
    .ex_mem_read   (EX_MemRead),
    .ex_write_reg  (EX_WriteReg),
    .mem_mem_read  (MEM_MemRead),
    .mem_write_reg (MEM_WriteReg),
    .single_haz    (single_haz),
    .double_haz    (double_haz)
  );

  // HOLD2 ignores the hazard inputs: the load-to-branch stall always lasts two cycles.
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    stallstall = 1'b0;
    case (state_q)
      RUN: begin
        stall = single_haz | double_haz;
        if (double_haz) state_d = HOLD2;
      end
      HOLD2: begin
        stallstall = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign flush          = stall | stallstall;
  assign PC_En          = ~flush;
  assign ID_EX_Flush    = flush;
  assign stall_cycles_d = stall_cycles_q + {31'd0, flush};
  assign stall_cycles   = stall_cycles_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q        <= RUN;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors queue expected outputs, a negedge monitor compares.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] id_inst = 32'd0;
  logic        ex_rw = 1'b0;
  logic        ex_mr = 1'b0;
  logic [4:0]  ex_wr = 5'd0;
  logic        mem_mr = 1'b0;
  logic [4:0]  mem_wr = 5'd0;
  logic        stall;
  logic        stallstall;
  logic        pc_en;
  logic        flush;
  logic [31:0] stall_cycles;

  typedef struct packed {
    logic        chk;
    logic        st;
    logic        ss;
    logic        pc;
    logic        fl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  logic [31:0] exp_cnt = 32'd0;
  int          checks = 0;
  int          failures = 0;

  localparam logic [31:0] I_ADD  = 32'h00221820;  // add $3,$1,$2
  localparam logic [31:0] I_BEQ  = 32'h10220004;  // beq $1,$2
  localparam logic [31:0] I_JR5  = 32'h00A00008;  // jr $5
  localparam logic [31:0] I_JR0  = 32'h00000008;  // jr $0
  localparam logic [31:0] I_LW   = 32'h8C220000;  // lw $2,0($1)

  hazard_ctrl dut (
    .Clk          (clk),
    .Reset        (rst_n),
    .ID_Inst      (id_inst),
    .EX_RegWrite  (ex_rw),
    .EX_MemRead   (ex_mr),
    .EX_WriteReg  (ex_wr),
    .MEM_MemRead  (mem_mr),
    .MEM_WriteReg (mem_wr),
    .stall        (stall),
    .stallstall   (stallstall),
    .PC_En        (pc_en),
    .ID_EX_Flush  (flush),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=0x%08h required=0x%08h", nm, fld, act, req);
    end
  endtask

  // Monitor: one queued expectation per clock cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.chk) begin
        cmp(nm, "stall",        {31'd0, stall},      {31'd0, e.st});
        cmp(nm, "stallstall",   {31'd0, stallstall}, {31'd0, e.ss});
        cmp(nm, "PC_En",        {31'd0, pc_en},      {31'd0, e.pc});
        cmp(nm, "ID_EX_Flush",  {31'd0, flush},      {31'd0, e.fl});
        cmp(nm, "stall_cycles", stall_cycles,        e.cnt);
      end
    end
  end

  // Drive one cycle of inputs and queue the hand-computed outputs for that cycle.
  task automatic step(input logic rst, input logic chk, input logic [31:0] inst,
                      input logic erw, input logic emr, input logic [4:0] ewr,
                      input logic mmr, input logic [4:0] mwr,
                      input logic es, input logic ess, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n   = rst;
    id_inst = inst;
    ex_rw   = erw;
    ex_mr   = emr;
    ex_wr   = ewr;
    mem_mr  = mmr;
    mem_wr  = mwr;
    e.chk = chk;
    e.st  = es;
    e.ss  = ess;
    e.pc  = ~(es | ess);
    e.fl  = es | ess;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (!rst) exp_cnt = 32'd0;
    else if (es | ess) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic idle(input string nm, input logic ess);
    step(1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, ess, nm);
  endtask

  initial begin
    exp_t e;
    //    rst   chk   inst   erw   emr   ewr    mmr   mwr    st    ss
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, "reset0");
    step(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, "reset1");
    idle("idle_a", 1'b0);
    idle("idle_b", 1'b0);

    step(1'b1, 1'b1, I_ADD, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, "h1_loaduse");
    idle("h1_after", 1'b0);
    step(1'b1, 1'b1, I_ADD, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, "h1_reg0");
    step(1'b1, 1'b1, I_ADD, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, "h1_nomatch");
    step(1'b1, 1'b1, I_LW,  1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, "lw_rt_unused");

    step(1'b1, 1'b1, I_BEQ, 1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, "h3_first");
    idle("h3_second", 1'b1);
    idle("h3_after", 1'b0);

    step(1'b1, 1'b1, I_JR5, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b1, 1'b0, "h2_jr");
    idle("h2_after", 1'b0);
    step(1'b1, 1'b1, I_JR0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, "h2_reg0");
    step(1'b1, 1'b1, I_BEQ, 1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0, "h4_mem");
    idle("h4_after", 1'b0);

    // Hazard inputs held through HOLD2, then re-evaluated in the following RUN cycle.
    step(1'b1, 1'b1, I_BEQ, 1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, "h3b_first");
    step(1'b1, 1'b1, I_BEQ, 1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b1, "h3b_hold");
    step(1'b1, 1'b1, I_BEQ, 1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, "h3b_again");
    idle("h3b_hold2", 1'b1);
    idle("h3b_after", 1'b0);

    step(1'b1, 1'b1, I_BEQ, 1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, "rst_mid_h3");
    step(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, "rst_mid_hold");
    idle("rst_mid_after", 1'b0);
    idle("rst_mid_idle", 1'b0);

    // Counter wrap: preload the counter through a force released before the edge.
    @(posedge clk);
    #1;
    force dut.stall_cycles_q = 32'hFFFF_FFFF;
    id_inst = I_ADD;
    ex_rw   = 1'b0;
    ex_mr   = 1'b1;
    ex_wr   = 5'd1;
    mem_mr  = 1'b0;
    mem_wr  = 5'd0;
    e.chk = 1'b1;
    e.st  = 1'b1;
    e.ss  = 1'b0;
    e.pc  = 1'b0;
    e.fl  = 1'b1;
    e.cnt = 32'hFFFF_FFFF;
    exp_q.push_back(e);
    name_q.push_back("wrap_pre");
    exp_cnt = 32'd0;
    @(negedge clk);
    #1;
    release dut.stall_cycles_q;
    idle("wrap_post", 1'b0);
    idle("wrap_idle", 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Structural invariant sampled every checked cycle.
  always @(negedge clk) begin
    if (rst_n && (stall & stallstall)) begin
      failures++;
      $display("FAIL exclusive actual=%0b%0b required=not_both", stall, stallstall);
    end
  end

endmodule
